// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative multi-mode shifter.
package shifter_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_ASH = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_RCC = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_step.sv
// Combinational shift of {carry, value} by k (0..Step) single-bit moves.
// The step-overflow output exists only when SHIFTER_OVERFLOW_EN is defined.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned Step = 1,
  parameter int unsigned Aw   = 5
) (
  input  logic [1:0]    mode_i,
  input  logic          dir_i,
  input  logic [Aw-1:0] k_i,
  input  logic [N-1:0]  value_i,
  input  logic          carry_i,
  output logic [N-1:0]  value_o,
`ifdef SHIFTER_OVERFLOW_EN
  output logic          ovf_o,
`endif
  output logic          carry_o
);

  logic [N-1:0] v;
  logic         c;
  logic         b;
`ifdef SHIFTER_OVERFLOW_EN
  logic         ovf;
`endif

  always_comb begin
    v = value_i;
    c = carry_i;
    b = 1'b0;
`ifdef SHIFTER_OVERFLOW_EN
    ovf = 1'b0;
`endif
    // Unrolled single-bit moves so per-bit overflow is observed inside a multi-bit step.
    for (int i = 0; i < int'(Step); i++) begin
      if (i < int'(k_i)) begin
        if (dir_i == DIR_LEFT) begin
          b = v[N-1];
`ifdef SHIFTER_OVERFLOW_EN
          if (mode_i == MODE_LSL) ovf = ovf | v[N-1];
          else if (mode_i == MODE_ASH) ovf = ovf | (v[N-1] ^ v[N-2]);
`endif
          case (mode_i)
            MODE_ROT: v = {v[N-2:0], b};
            MODE_RCC: v = {v[N-2:0], c};
            default:  v = {v[N-2:0], 1'b0};
          endcase
          c = b;
        end else begin
          b = v[0];
          case (mode_i)
            MODE_LSL: v = {1'b0, v[N-1:1]};
            MODE_ASH: v = {v[N-1], v[N-1:1]};
            MODE_ROT: v = {b, v[N-1:1]};
            MODE_RCC: v = {c, v[N-1:1]};
          endcase
          c = b;
        end
      end
    end
  end

  assign value_o = v;
  assign carry_o = c;
`ifdef SHIFTER_OVERFLOW_EN
  assign ovf_o   = ovf;
`endif

endmodule

// File: rtl/multi_shifter.sv
// Iterative multi-mode shifter moving up to STEP bits per clock behind a start/finished handshake.
// Define SHIFTER_OVERFLOW_EN to add the o_overflow output.
module multi_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 1,
  localparam int unsigned AW  = $clog2(N) + 2
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_finished,
  input  logic          i_direction,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_amount,
  input  logic          i_carry,
  input  logic [N-1:0]  i_value,
  output logic [N-1:0]  o_value,
`ifdef SHIFTER_OVERFLOW_EN
  output logic          o_overflow,
`endif
  output logic          o_carry
);

  state_e        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic          wcarry_q, wcarry_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir_q, dir_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [N-1:0]  value_q, value_d;
  logic          carry_q, carry_d;
  logic [AW-1:0] step_k;
  logic [N-1:0]  step_value;
  logic          step_carry;
`ifdef SHIFTER_OVERFLOW_EN
  logic          step_ovf;
  logic          ovf_acc_q, ovf_acc_d;
  logic          ovf_q, ovf_d;
`endif

  assign step_k = (rem_q > AW'(STEP)) ? AW'(STEP) : rem_q;

  shifter_step #(
    .N    (N),
    .Step (STEP),
    .Aw   (AW)
  ) u_step (
    .mode_i  (mode_q),
    .dir_i   (dir_q),
    .k_i     (step_k),
    .value_i (work_q),
    .carry_i (wcarry_q),
    .value_o (step_value),
`ifdef SHIFTER_OVERFLOW_EN
    .ovf_o   (step_ovf),
`endif
    .carry_o (step_carry)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    wcarry_d = wcarry_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    value_d  = value_q;
    carry_d  = carry_q;
`ifdef SHIFTER_OVERFLOW_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_start) begin
          state_d  = S_SHIFT;
          work_d   = i_value;
          wcarry_d = i_carry;
          mode_d   = i_mode;
          dir_d    = i_direction;
          rem_d    = i_amount;
`ifdef SHIFTER_OVERFLOW_EN
          ovf_acc_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        work_d   = step_value;
        wcarry_d = step_carry;
        rem_d    = rem_q - step_k;
`ifdef SHIFTER_OVERFLOW_EN
        ovf_acc_d = ovf_acc_q | step_ovf;
`endif
        // Outputs change only on the final move so they stay stable while busy.
        if (rem_d == '0) begin
          state_d = S_DONE;
          value_d = step_value;
          carry_d = step_carry;
`ifdef SHIFTER_OVERFLOW_EN
          ovf_d   = ovf_acc_q | step_ovf;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      wcarry_q <= 1'b0;
      mode_q   <= MODE_LSL;
      dir_q    <= DIR_LEFT;
      rem_q    <= '0;
      value_q  <= '0;
      carry_q  <= 1'b0;
`ifdef SHIFTER_OVERFLOW_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      wcarry_q <= wcarry_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      value_q  <= value_d;
      carry_q  <= carry_d;
`ifdef SHIFTER_OVERFLOW_EN
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign o_busy     = (state_q == S_SHIFT);
  assign o_finished = (state_q == S_DONE);
  assign o_value    = value_q;
  assign o_carry    = carry_q;
`ifdef SHIFTER_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule
